// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: sequential increment plus optional relative redirect.
module pc_next #(
    parameter int unsigned ADDR_W = fetch_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] pc_out
);

    // Increment and optionally add the offset; all arithmetic wraps at ADDR_W bits.
    always_comb begin
        pc_out = pc_in + ADDR_W'(1);
        if (branch_take) begin
            pc_out = pc_out + branch_offset;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests one word at a time from instruction
// memory, presents it to decode, and advances or redirects the PC on accept.
// Optional feature: define FETCH_SEQUENCER_TIMEOUT_EN to add a memory wait
// timeout that parks the block in an error state with sticky fetch_err.
module fetch_sequencer #(
    parameter int unsigned              ADDR_W   = fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]        RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
    parameter int unsigned              MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic              fetch_err
);

    import fetch_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic              load_instr;
    logic              load_pc;

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
`endif

    assign imem_addr = pc;

    pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc_in         (instr_pc),
        .branch_take   (branch_take),
        .branch_offset (branch_offset),
        .pc_out        (pc_nxt)
    );

    // Next-state and datapath-load decisions.
    always_comb begin
        state_next = state;
        load_instr = 1'b0;
        load_pc    = 1'b0;
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
        wait_next  = wait_cnt;
`endif
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
                wait_next  = '0;
`endif
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = ST_HOLD;
                end
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
                else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                    state_next = ST_ERR;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
`endif
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    load_pc    = 1'b1;
                    state_next = ST_FETCH;
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
                    wait_next  = '0;
`endif
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // State, PC, request/valid flags and the captured instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_next;
            imem_req    <= (state_next == ST_FETCH);
            instr_valid <= (state_next == ST_HOLD);
            if (load_instr) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (load_pc) begin
                pc <= pc_nxt;
            end
        end
    end

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            wait_cnt  <= wait_next;
            fetch_err <= fetch_err | (state_next == ST_ERR);
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a transaction model.
module tb_fetch_sequencer;

    localparam int unsigned AW   = 20;
    localparam int unsigned MAXW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [AW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          branch_take;
    logic [AW-1:0] branch_offset;
    logic          fetch_err;

    fetch_sequencer #(
        .ADDR_W   (AW),
        .RESET_PC (20'h00000),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .branch_take   (branch_take),
        .branch_offset (branch_offset),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level expectations.
    logic [AW-1:0] exp_pc;
    logic          exp_req;
    logic          exp_valid;
    logic [AW-1:0] exp_instr;
    logic [AW-1:0] exp_ipc;
    logic          exp_err;
    logic          started;
    int            wcnt;

    function automatic logic [AW-1:0] mem_word(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = a * 20'h09E37;
        return m ^ 20'h5A5A5;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("imem_req",    32'(imem_req),    32'(exp_req));
        check_val("imem_addr",   32'(imem_addr),   32'(exp_pc));
        check_val("instr_valid", 32'(instr_valid), 32'(exp_valid));
        check_val("instr",       32'(instr),       32'(exp_instr));
        check_val("instr_pc",    32'(instr_pc),    32'(exp_ipc));
        check_val("fetch_err",   32'(fetch_err),   32'(exp_err));
    endtask

    // Apply one cycle of inputs at the falling edge, advance the model, check after the edge.
    task automatic cycle(input logic ack, input logic rdy, input logic bt, input logic [AW-1:0] off);
        imem_ack      = ack;
        instr_ready   = rdy;
        branch_take   = bt;
        branch_offset = off;
        imem_rdata    = mem_word(imem_addr);
        if (!started) begin
            started = 1'b1;
            exp_req = 1'b1;
            wcnt    = 0;
        end else if (exp_err) begin
            exp_req = 1'b0;
        end else if (exp_req) begin
            if (ack) begin
                exp_req   = 1'b0;
                exp_valid = 1'b1;
                exp_instr = mem_word(exp_pc);
                exp_ipc   = exp_pc;
            end else begin
                wcnt++;
`ifdef FETCH_SEQUENCER_TIMEOUT_EN
                if (wcnt >= int'(MAXW)) begin
                    exp_err = 1'b1;
                    exp_req = 1'b0;
                end
`endif
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
            exp_req   = 1'b1;
            wcnt      = 0;
            exp_pc    = exp_ipc + AW'(1) + (bt ? off : AW'(0));
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Assert reset asynchronously, check immediate effect, release on a falling edge.
    task automatic do_reset();
        reset     = 1'b0;
        exp_pc    = '0;
        exp_req   = 1'b0;
        exp_valid = 1'b0;
        exp_instr = '0;
        exp_ipc   = '0;
        exp_err   = 1'b0;
        started   = 1'b0;
        wcnt      = 0;
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        instr_ready   = 1'b0;
        branch_take   = 1'b0;
        branch_offset = '0;
        @(negedge clk);
        do_reset();

        // Zero-wait memory, sequential stream 0,1,2.
        cycle(1'b0, 1'b0, 1'b0, '0);
        check_val("first_addr", 32'(imem_addr), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check_val("lat1_valid", 32'(instr_valid), 32'h1);
        check_val("seq_pc0", 32'(instr_pc), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check_val("seq_pc1", 32'(instr_pc), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check_val("seq_pc2", 32'(instr_pc), 32'h2);

        // Five-cycle decode stall, branch_take outside a handshake.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), AW'($urandom));
        end
        check_val("stall_pc", 32'(instr_pc), 32'h2);
        check_val("stall_req", 32'(imem_req), 32'h0);
        check_val("stall_addr", 32'(imem_addr), 32'h2);

        // Branch to 0x10, then branch +5 from 0x10.
        cycle(1'b0, 1'b1, 1'b1, 20'h0000D);
        check_val("br_to_10", 32'(imem_addr), 32'h10);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 20'h00005);
        check_val("br_plus5", 32'(imem_addr), 32'h16);
        cycle(1'b0, 1'b0, 1'b1, 20'h00123);
        check_val("br_in_fetch", 32'(imem_addr), 32'h16);
        cycle(1'b1, 1'b0, 1'b0, '0);

        // Wrap at the top of the address space.
        cycle(1'b0, 1'b1, 1'b1, 20'hFFFE8);
        check_val("to_fffff", 32'(imem_addr), 32'hFFFFF);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check_val("wrap_inc", 32'(imem_addr), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 20'h00002);
        check_val("to_3", 32'(imem_addr), 32'h3);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 20'hFFFFE);
        check_val("neg_off", 32'(imem_addr), 32'h2);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 3) == 0), AW'($urandom));
        end

        // Reset while a request is pending.
        for (int i = 0; i < 4 && !exp_req; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        check_val("pre_rst_req", 32'(imem_req), 32'h1);
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, '0);
        check_val("restart_addr", 32'(imem_addr), 32'h0);
        check_val("restart_req", 32'(imem_req), 32'h1);

`ifdef FETCH_SEQUENCER_TIMEOUT_EN
        for (int i = 0; i < int'(MAXW) - 1; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
        end
        check_val("err_early", 32'(fetch_err), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check_val("err_set", 32'(fetch_err), 32'h1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
        end
        check_val("err_sticky", 32'(fetch_err), 32'h1);
        check_val("err_req", 32'(imem_req), 32'h0);
        do_reset();
        check_val("err_cleared", 32'(fetch_err), 32'h0);
`else
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
        end
        check_val("wait_req", 32'(imem_req), 32'h1);
        check_val("wait_err", 32'(fetch_err), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
